// File: rtl/gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2
  } meas_state_e;

  localparam int unsigned SETTLE_CYC = 8;
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_CYC);
  localparam int unsigned SYNC_DEPTH = 2;

  // A single ring still needs a one-bit select so the port never collapses to zero width.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__ro_edge_sync.sv
// Brings the selected ring output into the CLK domain and emits a one-cycle
// pulse for every rising edge seen after synchronisation.
module gf180mcu_fd_sc_mcu7t5v0__ro_edge_sync
  import gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], ro_in};
    edge_d = sync_q[SYNC_DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign rise = sync_q[SYNC_DEPTH-1] & ~edge_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enables one ring, lets it settle,
// counts its synchronised rising edges over a programmable CLK window.
module gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl
  import gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl_pkg::*;
#(
  parameter  int unsigned N_RO   = 4,
  parameter  int unsigned GATE_W = 16,
  parameter  int unsigned CNT_W  = 20,
  localparam int unsigned SEL_W  = sel_width(N_RO)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [SEL_W-1:0]  SEL,
  input  logic [GATE_W-1:0] GATE_LEN,
  input  logic [N_RO-1:0]   RO_CLK,
  output logic [N_RO-1:0]   RO_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  meas_state_e       state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [GATE_W-1:0] win_q, win_d;
  logic [GATE_W-1:0] gate_len_q, gate_len_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_RO-1:0]   ro_en_q, ro_en_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic ro_sel;
  logic rise;

  // An out-of-range select picks no ring, so the edge path simply sees a constant low.
  always_comb begin
    ro_sel = 1'b0;
    for (int i = 0; i < N_RO; i++) begin
      if (sel_q == SEL_W'(i)) ro_sel = RO_CLK[i];
    end
  end

  gf180mcu_fd_sc_mcu7t5v0__ro_edge_sync u_edge_sync (
    .clk   (CLK),
    .rst   (RST),
    .ro_in (ro_sel),
    .rise  (rise)
  );

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    win_d      = win_q;
    gate_len_d = gate_len_q;
    sel_d      = sel_q;
    ro_en_d    = ro_en_q;
    done_d     = 1'b0;
    count_d    = count_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          sel_d      = SEL;
          gate_len_d = GATE_LEN;
          count_d    = '0;
          ovf_d      = 1'b0;
          settle_d   = '0;
          for (int i = 0; i < N_RO; i++) begin
            ro_en_d[i] = (SEL == SEL_W'(i));
          end
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          win_d   = '0;
          state_d = GATE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end

      // The window is exhausted once GATE_LEN pulses have been sampled; the
      // following edge closes the measurement.
      GATE: begin
        if (win_q == gate_len_q) begin
          ro_en_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          win_d = win_q + GATE_W'(1);
          if (rise) begin
            if (count_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        ro_en_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      win_q      <= '0;
      gate_len_q <= '0;
      sel_q      <= '0;
      ro_en_q    <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      win_q      <= win_d;
      gate_len_q <= gate_len_d;
      sel_q      <= sel_d;
      ro_en_q    <= ro_en_d;
      done_q     <= done_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign RO_EN = ro_en_q;
  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl.sv
// Directed bench for the ring-oscillator measurement controller, covering the
// default build and a narrow-counter, three-ring build.
module tb_gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [1:0]  sel;
  logic [15:0] gate_len;

  logic ring4 = 1'b0;
  logic ring8 = 1'b0;
  logic [3:0] ro_a;
  logic [2:0] ro_b;

  logic [3:0]  en_a;
  logic        busy_a, done_a, ovf_a;
  logic [19:0] count_a;
  logic [2:0]  en_b;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;
  always #20 ring4 = ~ring4;
  always #40 ring8 = ~ring8;

  assign ro_a = {1'b0, ring8, 1'b0, ring4};
  assign ro_b = {1'b0, ring4, ring8};

  gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl dut_a (
    .CLK      (clk),
    .RST      (rst),
    .START    (start_a),
    .SEL      (sel),
    .GATE_LEN (gate_len),
    .RO_CLK   (ro_a),
    .RO_EN    (en_a),
    .BUSY     (busy_a),
    .DONE     (done_a),
    .COUNT    (count_a),
    .OVF      (ovf_a)
  );

  gf180mcu_fd_sc_mcu7t5v0__ro_meas_ctrl #(.N_RO(3), .CNT_W(4)) dut_b (
    .CLK      (clk),
    .RST      (rst),
    .START    (start_b),
    .SEL      (sel),
    .GATE_LEN (gate_len),
    .RO_CLK   (ro_b),
    .RO_EN    (en_b),
    .BUSY     (busy_b),
    .DONE     (done_b),
    .COUNT    (count_b),
    .OVF      (ovf_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that accepts START.
  task automatic applyStimulus(input bit use_b, input logic [1:0] s, input logic [15:0] gl);
    sel      = s;
    gate_len = gl;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitDone(input bit use_b, input logic [3:0] exp_en, input int inject_at,
                          output int lat, output int en_cycles, output bit en_bad);
    logic [3:0] en;
    logic       bsy, dn;
    lat       = 0;
    en_cycles = 0;
    en_bad    = 1'b0;
    en  = use_b ? {1'b0, en_b} : en_a;
    bsy = use_b ? busy_b : busy_a;
    if (en != 4'b0) en_cycles++;
    if (en !== (bsy ? exp_en : 4'b0)) en_bad = 1'b1;
    dn = 1'b0;
    while (!dn && lat < 300) begin
      step();
      lat++;
      if (lat == inject_at) begin
        start_a = 1'b1;
        sel     = 2'd0;
      end else if (lat == inject_at + 1) begin
        start_a = 1'b0;
      end
      en  = use_b ? {1'b0, en_b} : en_a;
      bsy = use_b ? busy_b : busy_a;
      dn  = use_b ? done_b : done_a;
      if (en != 4'b0) en_cycles++;
      if (en !== (bsy ? exp_en : 4'b0)) en_bad = 1'b1;
    end
    if (!dn) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat, enc, extra_busy, extra_done;
    bit  bad;

    rst      = 1'b1;
    start_a  = 1'b1;
    start_b  = 1'b1;
    sel      = 2'd0;
    gate_len = 16'd0;
    repeat (3) step();
    checkOutput("rst_busy_a", busy_a, 1'b0);
    checkOutput("rst_en_a", en_a, 4'b0);
    checkOutput("rst_done_a", done_a, 1'b0);
    checkOutput("rst_count_a", count_a, 20'd0);
    checkOutput("rst_ovf_a", ovf_a, 1'b0);
    checkOutput("rst_busy_b", busy_b, 1'b0);
    checkOutput("rst_en_b", en_b, 3'b0);
    start_a = 1'b0;
    start_b = 1'b0;
    rst     = 1'b0;
    step();
    checkOutput("idle_busy_a", busy_a, 1'b0);

    $display("[TB] CLK/8 ring, SEL=2, GATE_LEN=64");
    applyStimulus(1'b0, 2'd2, 16'd64);
    checkOutput("m1_en", en_a, 4'b0100);
    checkOutput("m1_busy", busy_a, 1'b1);
    waitDone(1'b0, 4'b0100, -1, lat, enc, bad);
    checkOutput("m1_latency", lat, 73);
    checkOutput("m1_count_range", (count_a >= 20'd7 && count_a <= 20'd9), 1'b1);
    checkOutput("m1_ovf", ovf_a, 1'b0);
    checkOutput("m1_en_stable", bad, 1'b0);
    checkOutput("m1_busy_at_done", busy_a, 1'b0);
    checkOutput("m1_en_at_done", en_a, 4'b0);
    step();
    checkOutput("m1_done_one_cycle", done_a, 1'b0);
    checkOutput("m1_count_held", (count_a >= 20'd7 && count_a <= 20'd9), 1'b1);

    $display("[TB] GATE_LEN=0");
    applyStimulus(1'b0, 2'd2, 16'd0);
    checkOutput("m2_count_cleared", count_a, 20'd0);
    waitDone(1'b0, 4'b0100, -1, lat, enc, bad);
    checkOutput("m2_latency", lat, 9);
    checkOutput("m2_en_cycles", enc, 9);
    checkOutput("m2_count", count_a, 20'd0);
    checkOutput("m2_en_stable", bad, 1'b0);

    $display("[TB] START and SEL change while busy");
    applyStimulus(1'b0, 2'd2, 16'd64);
    waitDone(1'b0, 4'b0100, 20, lat, enc, bad);
    checkOutput("m3_latency", lat, 73);
    checkOutput("m3_en_stable", bad, 1'b0);
    checkOutput("m3_count_range", (count_a >= 20'd7 && count_a <= 20'd9), 1'b1);
    extra_busy = 0;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      extra_busy += int'(busy_a);
      extra_done += int'(done_a);
    end
    checkOutput("m3_no_requeue_busy", extra_busy, 0);
    checkOutput("m3_no_second_done", extra_done, 0);

    $display("[TB] reset during GATE");
    applyStimulus(1'b0, 2'd2, 16'd64);
    repeat (30) step();
    checkOutput("m4_mid_count_nonzero", (count_a != 20'd0), 1'b1);
    rst = 1'b1;
    step();
    checkOutput("m4_rst_en", en_a, 4'b0);
    checkOutput("m4_rst_busy", busy_a, 1'b0);
    checkOutput("m4_rst_count", count_a, 20'd0);
    checkOutput("m4_rst_ovf", ovf_a, 1'b0);
    checkOutput("m4_rst_done", done_a, 1'b0);
    rst = 1'b0;
    extra_busy = 0;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      extra_busy += int'(busy_a);
      extra_done += int'(done_a);
    end
    checkOutput("m4_no_done_after_rst", extra_done, 0);
    checkOutput("m4_idle_after_rst", extra_busy, 0);
    applyStimulus(1'b0, 2'd2, 16'd16);
    waitDone(1'b0, 4'b0100, -1, lat, enc, bad);
    checkOutput("m4_restart_latency", lat, 25);
    checkOutput("m4_restart_count_range", (count_a >= 20'd1 && count_a <= 20'd3), 1'b1);
    checkOutput("m4_restart_en_stable", bad, 1'b0);

    $display("[TB] narrow counter saturation, CLK/4 ring, GATE_LEN=100");
    applyStimulus(1'b1, 2'd1, 16'd100);
    checkOutput("m5_en", en_b, 3'b010);
    waitDone(1'b1, 4'b0010, -1, lat, enc, bad);
    checkOutput("m5_latency", lat, 109);
    checkOutput("m5_count_sat", count_b, 4'd15);
    checkOutput("m5_ovf", ovf_b, 1'b1);
    checkOutput("m5_en_stable", bad, 1'b0);

    $display("[TB] out-of-range SEL=3 on three-ring build");
    applyStimulus(1'b1, 2'd3, 16'd20);
    checkOutput("m6_ovf_cleared", ovf_b, 1'b0);
    checkOutput("m6_count_cleared", count_b, 4'd0);
    checkOutput("m6_busy", busy_b, 1'b1);
    checkOutput("m6_en_zero", en_b, 3'b0);
    waitDone(1'b1, 4'b0000, -1, lat, enc, bad);
    checkOutput("m6_latency", lat, 29);
    checkOutput("m6_count", count_b, 4'd0);
    checkOutput("m6_ovf", ovf_b, 1'b0);
    checkOutput("m6_en_never_set", enc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
